// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store memory access sequencer with alignment, funct3 and timeout checks
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  // Last ACCESS cycle index before the wait is abandoned.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  err_q;
  logic [1:0]  err_nx;
  logic [7:0]  wait_cnt;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        f3_illegal;
  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [3:0]  be_raw;

  // Start checks look at the live inputs, since they decide the state entered on the start edge.
  assign f3_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                      (funct3[2] && is_store);
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  // State register and the latched error code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 2'b00;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  // Next-state logic; a same-cycle ack takes precedence over the timeout.
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (f3_illegal) begin
            state_nx = FAULT;
            err_nx   = 2'b10;
          end else if (misaligned) begin
            state_nx = FAULT;
            err_nx   = 2'b01;
          end else begin
            state_nx = ACCESS;
            err_nx   = 2'b00;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_nx = DONE;
          err_nx   = 2'b00;
        end else if (wait_cnt == LAST_WAIT) begin
          state_nx = FAULT;
          err_nx   = 2'b11;
        end
      end
      DONE:    state_nx = IDLE;
      FAULT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the request on an accepted start; later input changes do not affect the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (state == IDLE && start) begin
      store_q <= is_store;
      f3_q    <= funct3;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Wait counter: cleared when the access begins, counts ACCESS cycles with no ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (state == IDLE) begin
      wait_cnt <= 8'd0;
    end else if (state == ACCESS && !mem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Align the addressed bytes to bit 0, then extend according to the width code.
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_val = shifted;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Load result register; only a successful load updates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (state == ACCESS && mem_ack && !store_q) begin
      rdata_q <= load_val;
    end
  end

  // Byte-enable pattern for the latched width and byte offset.
  always_comb begin
    be_raw = 4'b1111;
    case (f3_q[1:0])
      2'b00:   be_raw = 4'b0001 << addr_q[1:0];
      2'b01:   be_raw = 4'b0011 << addr_q[1:0];
      default: be_raw = 4'b1111;
    endcase
  end

  // Replicate store data into every lane so the enabled lanes always carry it.
  always_comb begin
    mem_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
  end

  assign mem_req  = (state == ACCESS);
  assign mem_we   = mem_req && store_q;
  assign mem_be   = (mem_req && store_q) ? be_raw : 4'b0000;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign done     = (state == DONE) || (state == FAULT);
  assign busy     = (state != IDLE);
  assign err      = done ? err_q : 2'b00;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, done, busy;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;
  logic [1:0]  err;

  logic        b_start, b_is_store, b_mem_ack;
  logic [2:0]  b_funct3;
  logic [31:0] b_addr, b_wdata, b_mem_rdata;
  logic        b_mem_req, b_mem_we, b_done, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_rdata;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_err;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata(rdata),
    .done(done), .busy(busy), .err(err)
  );

  mem_access_unit dut_def (
    .clk(clk), .rst(rst), .start(b_start), .is_store(b_is_store), .funct3(b_funct3),
    .addr(b_addr), .wdata(b_wdata), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .rdata(b_rdata),
    .done(b_done), .busy(b_busy), .err(b_err)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int accepted = 0;

  // Expected outputs for the current cycle, set by the stimulus process.
  bit          exp_on = 0;
  logic        e_req = 0, e_we = 0, e_done = 0, e_busy = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
  logic [3:0]  e_be = 0;
  logic [1:0]  e_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic from the access rules.
  function automatic bit m_illegal(bit st, logic [2:0] f);
    return (f == 3 || f == 6 || f == 7) || (st && f[2]);
  endfunction

  function automatic int m_bytes(logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit m_misal(logic [2:0] f, logic [31:0] a);
    return (a % m_bytes(f)) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f, logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int off = int'(a % 4);
    for (int k = 0; k < m_bytes(f); k++) be[off + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f, logic [31:0] wd);
    logic [31:0] w = 0;
    int n = m_bytes(f);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a, logic [31:0] rd);
    logic [31:0] v = 0;
    int n = m_bytes(f);
    int off = int'(a % 4);
    for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(off + k) +: 8];
    if (!f[2] && n < 4 && v[8*n - 1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // Compare process: DUT against the expectation at every falling edge.
  always @(negedge clk) begin
    if (exp_on) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("rdata", rdata, e_rdata);
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_done) chk("err", 32'(err), 32'(e_err));
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (mem_req === 1'b1) req_cnt <= req_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    start    = 1'($urandom_range(0, 1));
    is_store = 1'($urandom_range(0, 1));
    funct3   = 3'($urandom_range(0, 7));
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  task automatic txn(bit st, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                     logic [31:0] rd, int dly);
    bit ill = m_illegal(st, f);
    bit mis = !ill && m_misal(f, a);
    bit fin = 0;
    start = 1; is_store = st; funct3 = f; addr = a; wdata = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    e_busy = 0; e_done = 0; e_req = 0;
    step();
    accepted++;
    if (ill || mis) begin
      noise();
      mem_ack = 1'($urandom_range(0, 1));
      e_busy = 1; e_done = 1; e_req = 0; e_err = ill ? 2'b10 : 2'b01;
      step();
    end else begin
      e_req = 1; e_we = st; e_addr = {a[31:2], 2'b00};
      e_be = st ? m_be(f, a) : 4'b0000; e_wdata = m_wdata(f, wd);
      e_busy = 1; e_done = 0;
      for (int i = 0; i < TO && !fin; i++) begin
        noise();
        mem_ack = (i == dly);
        mem_rdata = (i == dly) ? rd : $urandom;
        step();
        if (i == dly) begin
          fin = 1; e_err = 2'b00;
          if (!st) e_rdata = m_load(f, a, rd);
        end else if (i == TO - 1) begin
          fin = 1; e_err = 2'b11;
        end
      end
      noise();
      mem_ack = 1'($urandom_range(0, 1));
      e_req = 0; e_done = 1;
      step();
    end
    e_done = 0; e_busy = 0; e_req = 0;
    start = 0; mem_ack = 0;
  endtask

  initial begin
    rst = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    b_start = 0; b_is_store = 0; b_funct3 = 0; b_addr = 0; b_wdata = 0;
    b_mem_ack = 0; b_mem_rdata = 0;
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    step(); step();
    rst = 0;
    exp_on = 1;
    step();

    // Model pins against hand-computed values.
    chk("pin_load_lb", m_load(3'b000, 32'h103, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("pin_load_lhu", m_load(3'b101, 32'h202, 32'hBEEF_0000), 32'h0000_BEEF);
    chk("pin_be_sh", 32'(m_be(3'b001, 32'h6)), 32'h0000_000C);
    chk("pin_wdata_sh", m_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk("pin_illegal", 32'(m_illegal(1'b1, 3'b100)), 1);

    // Directed loads, misaligned word, timeout and illegal funct3.
    txn(0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    txn(0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    req_cnt = 0;
    txn(0, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 0);
    chk("mis_rdata", rdata, 32'h0000_BEEF);
    chk("mis_noreq", 32'(req_cnt), 0);
    req_cnt = 0;
    txn(0, 3'b010, 32'h0000_0080, 32'h0, 32'h0, 99);
    chk("timeout_req_cycles", 32'(req_cnt), 4);
    txn(1, 3'b100, 32'h0000_0010, 32'h55, 32'h0, 0);
    txn(0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, TO - 1);
    chk("ack_at_limit", rdata, 32'hCAFE_F00D);

    // Half store on the default-timeout instance with 5 stalled cycles.
    b_start = 1; b_is_store = 1; b_funct3 = 3'b001; b_addr = 32'h6; b_wdata = 32'h1234_ABCD;
    step();
    b_start = 0; b_addr = 32'hFFFF_FFFF; b_wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      b_mem_ack = (i == 5);
      chk("sh_req", 32'(b_mem_req), 1);
      chk("sh_we", 32'(b_mem_we), 1);
      chk("sh_be", 32'(b_mem_be), 32'hC);
      chk("sh_wdata", b_mem_wdata, 32'hABCD_ABCD);
      chk("sh_addr", b_mem_addr, 32'h4);
      chk("sh_done_early", 32'(b_done), 0);
      step();
    end
    b_mem_ack = 0;
    chk("sh_done", 32'(b_done), 1);
    chk("sh_err", 32'(b_err), 0);
    chk("sh_req_off", 32'(b_mem_req), 0);
    step();
    chk("sh_idle", 32'(b_busy), 0);

    // Randomized accesses; busy cycles carry random starts and input changes.
    for (int n = 0; n < 300; n++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, TO - 1));
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, d);
    end

    // Reset in the second ACCESS cycle, then a late ack.
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40; mem_ack = 0;
    step();
    start = 0;
    e_req = 1; e_we = 0; e_addr = 32'h40; e_be = 0; e_wdata = m_wdata(3'b010, 32'h0);
    e_wdata = m_wdata(3'b010, wdata); e_busy = 1; e_done = 0;
    step();
    exp_on = 0;
    #2 rst = 1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    step();
    rst = 0;
    step();
    mem_ack = 1; mem_rdata = $urandom;
    step();
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_done", 32'(done), 0);
      chk("late_ack_busy", 32'(busy), 0);
      chk("late_ack_req", 32'(mem_req), 0);
      step();
    end
    chk("post_rst_rdata", rdata, 0);
    e_rdata = 0; e_req = 0; e_busy = 0; e_done = 0;
    exp_on = 1;

    // First start after reset is accepted normally.
    txn(0, 3'b000, 32'h0000_0011, 32'h0, 32'h0000_7F00, 0);
    chk("after_rst_load", rdata, 32'h0000_007F);

    start = 0; mem_ack = 0;
    step(); step();
    chk("done_count", 32'(done_cnt), 32'(accepted));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
